ram_2r1w_param: RTL and testbench

Parametrised 2-read / 1-write synchronous register file, generalising the team's fixed 2x2-bit RAM to configurable data width and depth. Adds registered read ports with write-first bypass, an optional hard-wired zero entry for CPU register-file use, and a multi-cycle hardware clear sequencer with a busy flag. Sits in the datapath as the general-purpose register file and as scratch storage for lab CPU builds.

---
 rtl/ram_2r1w_if.sv | 31 +++
 rtl/ram_2r1w_param.sv | 108 ++++++++++
 tb/tb_ram_2r1w_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_2r1w_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_2r1w_if : bus bundle for the 2-read/1-write register file  Rev 1.0|
// +----------------------------------------------------------------------+
interface ram_2r1w_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  Write_Enable;
   logic [ADDR_WIDTH-1:0] Write_Address;
   logic [WIDTH-1:0]      Write_Data;
   logic [ADDR_WIDTH-1:0] Read_Address_1;
   logic [ADDR_WIDTH-1:0] Read_Address_2;
   logic [WIDTH-1:0]      Read_Data_1;
   logic [WIDTH-1:0]      Read_Data_2;
   logic                  Clear;
   logic                  Busy;

   modport master (
      output Write_Enable, Write_Address, Write_Data,
      output Read_Address_1, Read_Address_2, Clear,
      input  Read_Data_1, Read_Data_2, Busy
   );

   modport slave (
      input  Write_Enable, Write_Address, Write_Data,
      input  Read_Address_1, Read_Address_2, Clear,
      output Read_Data_1, Read_Data_2, Busy
   );
endinterface
`default_nettype wire

// File: rtl/ram_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_2r1w_param : 2R/1W register file, write-first bypass, HW clear   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_2r1w_param #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int ZERO_REG   = 0
) (
   input  wire logic   clk,
   input  wire logic   reset,
   ram_2r1w_if.slave   bus
);
   localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(c_DEPTH - 1);
   localparam bit                    c_ZERO  = (ZERO_REG != 0);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0]      r_mem [c_DEPTH];
   logic [WIDTH-1:0]      r_rd1;
   logic [WIDTH-1:0]      r_rd2;
   logic [WIDTH-1:0]      w_rd1_nxt;
   logic [WIDTH-1:0]      w_rd2_nxt;
   logic                  w_sweep;
   logic                  w_user_we;
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [WIDTH-1:0]      w_wr_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (bus.Clear) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            // Repeated Clear pulses are ignored; the sweep only ends at the last entry.
            if (r_cnt == c_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_sweep   = (r_state == S_CLEAR);
      w_user_we = (r_state == S_IDLE) && bus.Write_Enable && !bus.Clear &&
                  !(c_ZERO && (bus.Write_Address == '0));
      w_wr_en   = w_sweep || w_user_we;
      w_wr_addr = w_sweep ? r_cnt : bus.Write_Address;
      w_wr_data = w_sweep ? '0    : bus.Write_Data;
   end

   // Write-first: a same-edge write to the read address wins over stored content.
   always_comb begin
      w_rd1_nxt = r_mem[bus.Read_Address_1];
      w_rd2_nxt = r_mem[bus.Read_Address_2];
      if (w_wr_en && (w_wr_addr == bus.Read_Address_1)) w_rd1_nxt = w_wr_data;
      if (w_wr_en && (w_wr_addr == bus.Read_Address_2)) w_rd2_nxt = w_wr_data;
      if (c_ZERO && (bus.Read_Address_1 == '0)) w_rd1_nxt = '0;
      if (c_ZERO && (bus.Read_Address_2 == '0)) w_rd2_nxt = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else begin
         if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
         r_rd1 <= w_rd1_nxt;
         r_rd2 <= w_rd2_nxt;
      end
   end

   assign bus.Read_Data_1 = r_rd1;
   assign bus.Read_Data_2 = r_rd2;
   assign bus.Busy        = (r_state == S_CLEAR);
endmodule
`default_nettype wire

// File: tb/tb_ram_2r1w_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_2r1w_param : directed scoreboard bench, ZERO_REG = 0 and 1    |
// +----------------------------------------------------------------------+
module tb_ram_2r1w_param;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] q1[$], q2[$], qz1[$], qz2[$];
   logic       qb[$];

   always #5 clk = ~clk;

   ram_2r1w_if #(.WIDTH(8), .ADDR_WIDTH(4)) b0 ();
   ram_2r1w_if #(.WIDTH(8), .ADDR_WIDTH(4)) bz ();

   assign bz.Write_Enable   = b0.Write_Enable;
   assign bz.Write_Address  = b0.Write_Address;
   assign bz.Write_Data     = b0.Write_Data;
   assign bz.Read_Address_1 = b0.Read_Address_1;
   assign bz.Read_Address_2 = b0.Read_Address_2;
   assign bz.Clear          = b0.Clear;

   ram_2r1w_param #(.WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   ram_2r1w_param #(.WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(1)) u_dutz (
      .clk   (clk),
      .reset (reset),
      .bus   (bz.slave)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected outputs, then compare after the edge.
   task automatic cyc(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic [3:0] ra1, input logic [3:0] ra2, input logic clr,
                      input logic [7:0] e1, input logic [7:0] e2, input logic eb);
      q1.push_back(e1);
      q2.push_back(e2);
      qz1.push_back((ra1 == 4'd0) ? 8'h00 : e1);
      qz2.push_back((ra2 == 4'd0) ? 8'h00 : e2);
      qb.push_back(eb);
      b0.Write_Enable   = we;
      b0.Write_Address  = wa;
      b0.Write_Data     = wd;
      b0.Read_Address_1 = ra1;
      b0.Read_Address_2 = ra2;
      b0.Clear          = clr;
      @(posedge clk);
      #1;
      begin
         logic       eb_q;
         eb_q = qb.pop_front();
         chk("rd1_z0", b0.Read_Data_1, q1.pop_front());
         chk("rd2_z0", b0.Read_Data_2, q2.pop_front());
         chk("rd1_z1", bz.Read_Data_1, qz1.pop_front());
         chk("rd2_z1", bz.Read_Data_2, qz2.pop_front());
         chk("busy_z0", {7'd0, b0.Busy}, {7'd0, eb_q});
         chk("busy_z1", {7'd0, bz.Busy}, {7'd0, eb_q});
      end
   endtask

   initial begin
      b0.Write_Enable   = 1'b0;
      b0.Write_Address  = '0;
      b0.Write_Data     = '0;
      b0.Read_Address_1 = '0;
      b0.Read_Address_2 = '0;
      b0.Clear          = 1'b0;

      #2 reset = 1'b1;
      #1;
      chk("rst_rd1", b0.Read_Data_1, 8'h00);
      chk("rst_rd2", b0.Read_Data_2, 8'h00);
      chk("rst_busy", {7'd0, b0.Busy}, 8'h00);
      chk("rst_rd1_z1", bz.Read_Data_1, 8'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Basic write then read on both ports
      cyc(1'b1, 4'd3, 8'h5A, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0, 8'h5A, 8'h5A, 1'b0);
      // Bypass on port 1, stored data on port 2
      cyc(1'b1, 4'd6, 8'h11, 4'd0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(1'b1, 4'd7, 8'hC3, 4'd7, 4'd6, 1'b0, 8'hC3, 8'h11, 1'b0);
      // Entry 0: ordinary storage in one DUT, hard-wired zero in the other
      cyc(1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0, 8'hFF, 8'hFF, 1'b0);
      cyc(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0, 8'hFF, 8'hFF, 1'b0);

      // Fill every entry with index+1
      for (int i = 0; i < 16; i++)
         cyc(1'b1, 4'(i), 8'(i + 1), 4'(i), 4'd15, 1'b0,
             8'(i + 1), (i == 15) ? 8'd16 : 8'd0, 1'b0);

      // Clear edge with a simultaneous write to entry 2: clear wins
      cyc(1'b1, 4'd2, 8'h77, 4'd2, 4'd0, 1'b1, 8'h03, 8'h01, 1'b1);
      // Sweep edges: entry k-1 cleared at edge k; entry 5 cleared at k=6
      for (int k = 1; k <= 16; k++)
         cyc(1'b1, 4'd10, 8'h99, 4'd5, 4'(k - 1), (k == 3),
             (k >= 6) ? 8'h00 : 8'h06, 8'h00, (k < 16));
      // First accepted write immediately after the sweep
      cyc(1'b1, 4'd9, 8'h42, 4'd9, 4'd0, 1'b0, 8'h42, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++)
         cyc(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0,
             (i == 9) ? 8'h42 : 8'h00, ((15 - i) == 9) ? 8'h42 : 8'h00, 1'b0);

      // Reset in the middle of a sweep while reading entry 9
      cyc(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b1, 8'h42, 8'h42, 1'b1);
      for (int k = 1; k <= 7; k++)
         cyc(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0, 8'h42, 8'h42, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_busy", {7'd0, b0.Busy}, 8'h00);
      chk("async_rd1", b0.Read_Data_1, 8'h00);
      chk("async_rd2", b0.Read_Data_2, 8'h00);
      chk("async_busy_z1", {7'd0, bz.Busy}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(1'b1, 4'd4, 8'h2B, 4'd5, 4'd5, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 4'd0, 8'h00, 4'd4, 4'd4, 1'b0, 8'h2B, 8'h2B, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
